deser_n: RTL and testbench
==========================

DESER_N -- requirements
Module: deser_n

Interface
REQ-001 SHALL have parameter input_size, default 2, parallel word width in bits; legal range >= 1.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port A  input  1  serial data bit.
REQ-005 SHALL have port a_valid  input  1  A carries a valid bit this cycle.
REQ-006 SHALL have port a_ready  output  1  block can accept a bit this cycle.
REQ-007 SHALL have port Z  output  input_size  assembled parallel word.
REQ-008 SHALL have port z_valid  output  1  Z holds an unconsumed word.
REQ-009 SHALL have port z_ack  input  1  consumer takes Z this cycle.
REQ-010 SHALL have port count  output  $clog2(input_size+1)  number of bits held in the shift buffer, 0..input_size.

Function
REQ-011 SHALL accept a bit on a rising clk edge iff a_valid && a_ready; no other edge changes count or the shift buffer, except a transfer (REQ-015/016).
REQ-012 SHALL order bits LSB-first: the k-th accepted bit of a word (k = 0..input_size-1) SHALL appear at Z[k].
REQ-013 SHALL double-buffer: an internal shift buffer fills while Z holds the previous word unchanged.
REQ-014 SHALL drive a_ready = (count != input_size), combinationally from count only, never from z_ack.
REQ-015 Direct transfer: on accepting the last bit (count == input_size-1), if !z_valid || z_ack, the next edge SHALL load Z with the complete word, set z_valid = 1, and set count = 0.
REQ-016 Pending transfer: if the last bit is accepted while z_valid && !z_ack, count SHALL become input_size (a_ready = 0); on the first later edge with z_ack = 1, Z SHALL load the buffered word, z_valid SHALL stay 1, and count SHALL become 0.
REQ-017 Latency: z_valid and the new Z SHALL be visible one cycle after the edge that accepts the last bit, when the output slot is free or is acked at that edge.
REQ-018 On z_ack with z_valid = 1 and no transfer at the same edge, z_valid SHALL clear to 0 and Z SHALL hold its value.
REQ-019 Simultaneous z_ack and transfer at the same edge: z_valid SHALL remain 1 with no bubble cycle, and Z SHALL take the new word.
REQ-020 z_ack while z_valid = 0 SHALL be ignored.
REQ-021 Z SHALL change only on a transfer edge or on reset.
REQ-022 With input_size = 1, every accepted bit SHALL be a complete word, following REQ-015/016.
REQ-023 a_valid with a_ready = 0 SHALL not shift, and the bit SHALL be dropped; holding A stable is the producer's duty.

Reset
REQ-024 While rst_n = 0, the block SHALL force, immediately and independent of clk: Z = 0, z_valid = 0, count = 0, shift buffer = 0, a_ready = 1.
REQ-025 Reset mid-word or with a pending transfer SHALL discard all partial and pending data.
REQ-026 The first edge after rst_n rises SHALL be able to accept a bit.

Verification (input_size = 4)
REQ-027 Pulse rst_n low asynchronously between edges -> Z = 4'b0000, z_valid = 0, count = 0 and a_ready = 1 without waiting for a clk edge.
REQ-028 Feed A = 1,0,1,1 on 4 consecutive cycles with a_valid = 1 and z_ack = 0 -> count steps 1,2,3,0; z_valid = 1 and Z = 4'b1101 one cycle after the 4th bit.
REQ-029 With Z = 4'b1101 unacked, feed 0,1,1,0 -> count = 4 and a_ready = 0; then assert z_ack for 1 cycle -> next cycle Z = 4'b0110, z_valid = 1, count = 0, a_ready = 1.
REQ-030 Assert z_ack on the same edge that accepts a word's 4th bit -> z_valid stays 1 with no low cycle, and Z updates to the new word.
REQ-031 Feed 2 bits, pulse rst_n low, then feed 0,0,0,1 -> only the post-reset bits are used, giving Z = 4'b1000.
REQ-032 Interleave a_valid = 0 idle cycles (pattern valid, idle, valid, idle, ...) -> count advances only on valid cycles, and the word completes after exactly 4 accepts.

Source files
------------

// File: rtl/deser_n.sv
// Serial-to-parallel deserializer, LSB first, with a double-buffered output word.
// A shift buffer fills while Z holds the previous word until the consumer acks it.
module deser_n #(
  parameter int input_size = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                A,
  input  logic                                a_valid,
  output logic                                a_ready,
  output logic [input_size-1:0]               Z,
  output logic                                z_valid,
  input  logic                                z_ack,
  output logic [$clog2(input_size+1)-1:0]     count
);

  localparam int cnt_w = $clog2(input_size + 1);
  localparam logic [cnt_w-1:0] cnt_full = cnt_w'(input_size);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(input_size - 1);

  logic [input_size-1:0] shift_q, shift_d;
  logic [input_size-1:0] z_q, z_d;
  logic                  zv_q, zv_d;
  logic [cnt_w-1:0]      count_q, count_d;

  logic                  accept;
  logic                  complete;
  logic                  transfer;
  logic [input_size-1:0] word;

  assign a_ready = (count_q != cnt_full);
  assign Z       = z_q;
  assign z_valid = zv_q;
  assign count   = count_q;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept   = a_valid && a_ready;
    word     = shift_q;
    for (int i = 0; i < input_size; i++) begin
      if (accept && (count_q == cnt_w'(i))) word[i] = A;
    end
    // A word is complete when its last bit lands now, or it is already parked waiting for the slot.
    complete = (accept && (count_q == cnt_last)) || (count_q == cnt_full);
    transfer = complete && (!zv_q || z_ack);

    shift_d = shift_q;
    count_d = count_q;
    z_d     = z_q;
    zv_d    = zv_q;
    if (transfer) begin
      z_d     = word;
      zv_d    = 1'b1;
      shift_d = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        shift_d = word;
        count_d = count_q + cnt_w'(1);
      end
      if (z_ack && zv_q) zv_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
  // NOTE: the shift buffer is reset too, since a partial word must never leak into the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      z_q     <= '0;
      zv_q    <= 1'b0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      z_q     <= z_d;
      zv_q    <= zv_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_deser_n.sv
// Self-checking bench for deser_n (input_size = 4): directed scenarios plus random
// traffic, compared against a queue-based behavioural model.
module tb_deser_n;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         A, a_valid, z_ack;
  logic         a_ready, z_valid;
  logic [N-1:0] Z;
  logic [2:0]   count;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: bits held as a queue, output slot as word + flag.
  int           m_q[$];
  logic [N-1:0] m_z;
  bit           m_v;

  deser_n #(.input_size(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .Z       (Z),
    .z_valid (z_valid),
    .z_ack   (z_ack),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_z = '0;
    m_v = 1'b0;
  endtask

  // One clock edge of the model, using the inputs that were presented before the edge.
  task automatic model_edge(input logic a, input logic v, input logic ack);
    bit           took_ack;
    logic [N-1:0] w;
    took_ack = ack && m_v;
    if (v && (m_q.size() != N)) m_q.push_back(int'(a));
    if ((m_q.size() == N) && (!m_v || took_ack)) begin
      w = '0;
      for (int k = 0; k < N; k++) w[k] = m_q[k][0];
      m_z = w;
      m_v = 1'b1;
      m_q.delete();
    end else if (took_ack) begin
      m_v = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Z"},       32'(Z),       32'(m_z));
    check({tag, ".z_valid"}, 32'(z_valid), 32'(m_v));
    check({tag, ".count"},   32'(count),   32'(m_q.size()));
    check({tag, ".a_ready"}, 32'(a_ready), 32'(m_q.size() != N));
  endtask

  task automatic cycle(input logic a, input logic v, input logic ack, input string tag);
    A = a; a_valid = v; z_ack = ack;
    @(posedge clk);
    model_edge(a, v, ack);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".Z"},       32'(Z),       32'h0);
    check({tag, ".z_valid"}, 32'(z_valid), 32'h0);
    check({tag, ".count"},   32'(count),   32'h0);
    check({tag, ".a_ready"}, 32'(a_ready), 32'h1);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] bits;
    rst_n = 1'b1; A = 1'b0; a_valid = 1'b0; z_ack = 1'b0;
    model_reset();
    #3;
    async_reset("reset0");

    // Four consecutive bits 1,0,1,1 without ack.
    bits = 4'b1101;
    for (int k = 0; k < N; k++) cycle(bits[k], 1'b1, 1'b0, "fill1");
    check("fill1.word", 32'(Z), 32'hD);
    check("fill1.valid", 32'(z_valid), 32'h1);

    // Second word parks in the buffer while Z is unacked.
    bits = 4'b0110;
    for (int k = 0; k < N; k++) cycle(bits[k], 1'b1, 1'b0, "park");
    check("park.count", 32'(count), 32'h4);
    check("park.ready", 32'(a_ready), 32'h0);
    cycle(1'b1, 1'b1, 1'b0, "park.drop");
    cycle(1'b0, 1'b0, 1'b1, "park.ack");
    check("park.word", 32'(Z), 32'h6);
    check("park.valid", 32'(z_valid), 32'h1);
    check("park.count0", 32'(count), 32'h0);

    // Ack on the same edge as the last bit: no bubble.
    bits = 4'b0011;
    for (int k = 0; k < N - 1; k++) cycle(bits[k], 1'b1, 1'b0, "same");
    cycle(bits[N-1], 1'b1, 1'b1, "same.last");
    check("same.word", 32'(Z), 32'h3);
    check("same.valid", 32'(z_valid), 32'h1);

    // Ack with no transfer clears valid and holds Z; stray ack is ignored.
    cycle(1'b0, 1'b0, 1'b1, "ack");
    check("ack.valid", 32'(z_valid), 32'h0);
    check("ack.hold", 32'(Z), 32'h3);
    cycle(1'b0, 1'b0, 1'b1, "ack.idle");

    // Partial word discarded by reset.
    cycle(1'b1, 1'b1, 1'b0, "part");
    cycle(1'b1, 1'b1, 1'b0, "part");
    async_reset("reset1");
    bits = 4'b1000;
    for (int k = 0; k < N; k++) cycle(bits[k], 1'b1, 1'b0, "post");
    check("post.word", 32'(Z), 32'h8);

    // Free the slot, then valid/idle interleaving.
    cycle(1'b0, 1'b0, 1'b1, "free");
    bits = 4'b0111;
    for (int k = 0; k < N; k++) begin
      cycle(bits[k], 1'b1, 1'b0, "ilv.v");
      cycle(1'b0, 1'b0, 1'b0, "ilv.i");
    end
    check("ilv.word", 32'(Z), 32'h7);

    // Pending word discarded by reset.
    for (int k = 0; k < N; k++) cycle(1'b1, 1'b1, 1'b0, "pend");
    async_reset("reset2");

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), "rand");
      if (t == 200) async_reset("reset3");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
